// File: rtl/id_stage_hz.sv
// RISC-V decode stage with built-in ID/EX register, write-back bypass and load-use bubbling.
// Define ID_ILLEGAL_DETECT_EN to add the registered id_ex_illegal flag for unknown opcodes.

`ifndef CONTROL_SIGNALS_WIDTH
`define CONTROL_SIGNALS_WIDTH 11
`endif
`ifndef CTRL_REG_WRITE
`define CTRL_REG_WRITE  0
`endif
`ifndef CTRL_ALU_SRC
`define CTRL_ALU_SRC    1
`endif
`ifndef CTRL_MEM_READ
`define CTRL_MEM_READ   2
`endif
`ifndef CTRL_MEM_WRITE
`define CTRL_MEM_WRITE  3
`endif
`ifndef CTRL_MEM_TO_REG
`define CTRL_MEM_TO_REG 4
`endif
`ifndef CTRL_BRANCH
`define CTRL_BRANCH     5
`endif
`ifndef CTRL_JUMP
`define CTRL_JUMP       6
`endif
`ifndef CTRL_ALU_OP_LO
`define CTRL_ALU_OP_LO  7
`endif
`ifndef CTRL_ALU_OP_HI
`define CTRL_ALU_OP_HI  10
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'b0001
`endif

module id_stage_hz #(
    parameter int XLEN            = 32,
    parameter int CTRL_W          = `CONTROL_SIGNALS_WIDTH,
    parameter int LOAD_USE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              if_id_valid,
    input  logic [XLEN-1:0]   if_id_pc,
    input  logic [31:0]       if_id_instruction,
    output logic [4:0]        rs1_addr,
    output logic [4:0]        rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [4:0]        mem_wb_rd_addr,
    input  logic [XLEN-1:0]   mem_wb_rd_data,
    input  logic              mem_wb_reg_write,
    output logic              hazard_stall,
    output logic [XLEN-1:0]   id_ex_pc,
    output logic [31:0]       id_ex_instruction,
    output logic [XLEN-1:0]   id_ex_rs1_data,
    output logic [XLEN-1:0]   id_ex_rs2_data,
    output logic [XLEN-1:0]   id_ex_immediate,
    output logic [4:0]        id_ex_rd_addr,
    output logic [4:0]        id_ex_rs1_addr,
    output logic [4:0]        id_ex_rs2_addr,
    output logic [CTRL_W-1:0] id_ex_control_signals,
`ifdef ID_ILLEGAL_DETECT_EN
    output logic              id_ex_illegal,
`endif
    output logic              id_ex_valid
);

    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [31:0] NOP_INSTR  = 32'h00000013;

    typedef enum logic [0:0] {ST_RUN, ST_BUBBLE} state_t;

    state_t            r_state;
    logic [1:0]        r_cnt;
    logic [XLEN-1:0]   r_pc;
    logic [31:0]       r_instr;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic [4:0]        r_rd;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_valid;

    logic [31:0]       w_instr;
    logic [6:0]        w_opcode;
    logic [4:0]        w_rd;
    logic [31:0]       w_imm32;
    logic [XLEN-1:0]   w_imm;
    logic [CTRL_W-1:0] w_ctrl;
    logic              w_use_rs1;
    logic              w_use_rs2;
    logic              w_load_hazard;
    logic [4:0]        w_src_addr [2];
    logic [XLEN-1:0]   w_src_rf   [2];
    logic [XLEN-1:0]   w_src_val  [2];

    assign w_instr  = if_id_instruction;
    assign w_opcode = w_instr[6:0];
    assign w_rd     = w_instr[11:7];
    assign rs1_addr = w_instr[19:15];
    assign rs2_addr = w_instr[24:20];

    assign w_src_addr[0] = rs1_addr;
    assign w_src_addr[1] = rs2_addr;
    assign w_src_rf[0]   = rs1_data;
    assign w_src_rf[1]   = rs2_data;

    // x0 reads as zero; otherwise the value being written back this cycle wins over the file
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            assign w_src_val[gi] = (w_src_addr[gi] == 5'd0) ? '0 :
                                   (mem_wb_reg_write && mem_wb_rd_addr == w_src_addr[gi]) ?
                                   mem_wb_rd_data : w_src_rf[gi];
        end
    endgenerate

    always_comb begin
        w_imm32   = '0;
        w_ctrl    = '0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC: begin
                w_imm32 = {w_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                           w_instr[30:21], 1'b0};
                w_ctrl[`CTRL_JUMP]      = 1'b1;
                w_ctrl[`CTRL_REG_WRITE] = 1'b1;
            end
            OPC_JALR: begin
                w_imm32   = {{20{w_instr[31]}}, w_instr[31:20]};
                w_use_rs1 = 1'b1;
                w_ctrl[`CTRL_JUMP]      = 1'b1;
                w_ctrl[`CTRL_REG_WRITE] = 1'b1;
            end
            OPC_BRANCH: begin
                w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                           w_instr[11:8], 1'b0};
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_ctrl[`CTRL_BRANCH] = 1'b1;
            end
            OPC_LOAD: begin
                w_imm32   = {{20{w_instr[31]}}, w_instr[31:20]};
                w_use_rs1 = 1'b1;
                w_ctrl[`CTRL_MEM_READ]   = 1'b1;
                w_ctrl[`CTRL_MEM_TO_REG] = 1'b1;
                w_ctrl[`CTRL_REG_WRITE]  = 1'b1;
                w_ctrl[`CTRL_ALU_SRC]    = 1'b1;
            end
            OPC_STORE: begin
                w_imm32   = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_ctrl[`CTRL_MEM_WRITE] = 1'b1;
                w_ctrl[`CTRL_ALU_SRC]   = 1'b1;
            end
            OPC_OPIMM: begin
                w_imm32   = {{20{w_instr[31]}}, w_instr[31:20]};
                w_use_rs1 = 1'b1;
                w_ctrl[`CTRL_REG_WRITE] = 1'b1;
                w_ctrl[`CTRL_ALU_SRC]   = 1'b1;
                if (w_instr[14:12] == 3'b000)
                    w_ctrl[`CTRL_ALU_OP_HI:`CTRL_ALU_OP_LO] = `ALU_ADD;
            end
            OPC_OP: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_ctrl[`CTRL_REG_WRITE] = 1'b1;
                if (w_instr[14:12] == 3'b000 && w_instr[31:25] == 7'b0)
                    w_ctrl[`CTRL_ALU_OP_HI:`CTRL_ALU_OP_LO] = `ALU_ADD;
            end
            default: ;
        endcase
    end

    assign w_imm = XLEN'($signed(w_imm32));

    // Only the instruction currently in ID/EX can still be a load in flight
    assign w_load_hazard = if_id_valid && r_valid && r_ctrl[`CTRL_MEM_READ] && (r_rd != 5'd0) &&
                           ((w_use_rs1 && r_rd == rs1_addr) || (w_use_rs2 && r_rd == rs2_addr));

    assign hazard_stall = (r_state == ST_BUBBLE) || (r_state == ST_RUN && w_load_hazard);

`ifdef ID_ILLEGAL_DETECT_EN
    logic r_illegal;
    logic w_illegal;
    assign w_illegal     = !(w_opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                              OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP});
    assign id_ex_illegal = r_illegal;

    always_ff @(posedge clk) begin
        if (reset)
            r_illegal <= 1'b0;
        else if (flush)
            r_illegal <= 1'b0;
        else if (!stall) begin
            if (r_state == ST_BUBBLE || w_load_hazard || !if_id_valid)
                r_illegal <= 1'b0;
            else
                r_illegal <= w_illegal;
        end
    end
`endif

    task automatic load_bubble();
        r_pc       <= '0;
        r_instr    <= NOP_INSTR;
        r_rs1_data <= '0;
        r_rs2_data <= '0;
        r_imm      <= '0;
        r_rd       <= '0;
        r_rs1      <= '0;
        r_rs2      <= '0;
        r_ctrl     <= '0;
        r_valid    <= 1'b0;
    endtask

    always_ff @(posedge clk) begin
        if (reset) begin
            load_bubble();
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
        end else if (flush) begin
            load_bubble();
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
        end else if (stall) begin
            r_state <= r_state;
        end else if (r_state == ST_BUBBLE) begin
            load_bubble();
            if (r_cnt <= 2'd1) begin
                r_state <= ST_RUN;
                r_cnt   <= 2'd0;
            end else begin
                r_cnt <= r_cnt - 2'd1;
            end
        end else if (w_load_hazard) begin
            load_bubble();
            if (LOAD_USE_CYCLES > 1) begin
                r_state <= ST_BUBBLE;
                r_cnt   <= 2'(LOAD_USE_CYCLES - 1);
            end
        end else if (!if_id_valid) begin
            load_bubble();
        end else begin
            r_pc       <= if_id_pc;
            r_instr    <= w_instr;
            r_rs1_data <= w_src_val[0];
            r_rs2_data <= w_src_val[1];
            r_imm      <= (w_opcode == OPC_OP) ? '0 : w_imm;
            r_rd       <= w_rd;
            r_rs1      <= rs1_addr;
            r_rs2      <= rs2_addr;
            r_ctrl     <= w_ctrl;
            r_valid    <= 1'b1;
        end
    end

    assign id_ex_pc              = r_pc;
    assign id_ex_instruction     = r_instr;
    assign id_ex_rs1_data        = r_rs1_data;
    assign id_ex_rs2_data        = r_rs2_data;
    assign id_ex_immediate       = r_imm;
    assign id_ex_rd_addr         = r_rd;
    assign id_ex_rs1_addr        = r_rs1;
    assign id_ex_rs2_addr        = r_rs2;
    assign id_ex_control_signals = r_ctrl;
    assign id_ex_valid           = r_valid;

endmodule

// File: tb/tb_id_stage_hz.sv
// Directed bench: a 32-bit single-bubble stage (a_*) and a 64-bit two-bubble stage (b_*) share stimulus.
module tb_id_stage_hz;

    logic        clk = 1'b0;
    logic        reset, stall, flush, if_valid, wb_we;
    logic [63:0] d_pc, d_rs1, d_rs2, d_wb;
    logic [31:0] instr;
    logic [4:0]  wb_rd;

    logic [4:0]  a_rs1_addr, a_rs2_addr, a_rd, a_rs1a, a_rs2a;
    logic        a_hz, a_valid;
    logic [31:0] a_pc, a_instr, a_rs1d, a_rs2d, a_imm;
    logic [10:0] a_ctrl;

    logic [4:0]  b_rs1_addr, b_rs2_addr, b_rd, b_rs1a, b_rs2a;
    logic        b_hz, b_valid;
    logic [63:0] b_pc, b_rs1d, b_rs2d, b_imm;
    logic [31:0] b_instr;
    logic [10:0] b_ctrl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_stage_hz #(.XLEN(32), .CTRL_W(11), .LOAD_USE_CYCLES(1)) u_a (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .if_id_valid(if_valid), .if_id_pc(d_pc[31:0]), .if_id_instruction(instr),
        .rs1_addr(a_rs1_addr), .rs2_addr(a_rs2_addr),
        .rs1_data(d_rs1[31:0]), .rs2_data(d_rs2[31:0]),
        .mem_wb_rd_addr(wb_rd), .mem_wb_rd_data(d_wb[31:0]), .mem_wb_reg_write(wb_we),
        .hazard_stall(a_hz), .id_ex_pc(a_pc), .id_ex_instruction(a_instr),
        .id_ex_rs1_data(a_rs1d), .id_ex_rs2_data(a_rs2d), .id_ex_immediate(a_imm),
        .id_ex_rd_addr(a_rd), .id_ex_rs1_addr(a_rs1a), .id_ex_rs2_addr(a_rs2a),
        .id_ex_control_signals(a_ctrl), .id_ex_valid(a_valid)
    );

    id_stage_hz #(.XLEN(64), .CTRL_W(11), .LOAD_USE_CYCLES(2)) u_b (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .if_id_valid(if_valid), .if_id_pc(d_pc), .if_id_instruction(instr),
        .rs1_addr(b_rs1_addr), .rs2_addr(b_rs2_addr),
        .rs1_data(d_rs1), .rs2_data(d_rs2),
        .mem_wb_rd_addr(wb_rd), .mem_wb_rd_data(d_wb), .mem_wb_reg_write(wb_we),
        .hazard_stall(b_hz), .id_ex_pc(b_pc), .id_ex_instruction(b_instr),
        .id_ex_rs1_data(b_rs1d), .id_ex_rs2_data(b_rs2d), .id_ex_immediate(b_imm),
        .id_ex_rd_addr(b_rd), .id_ex_rs1_addr(b_rs1a), .id_ex_rs2_addr(b_rs2a),
        .id_ex_control_signals(b_ctrl), .id_ex_valid(b_valid)
    );

    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] ADDI  = 32'h00A00093;
    localparam logic [31:0] ADDIM = 32'hFFF00093;
    localparam logic [31:0] ADD2  = 32'h00110133;
    localparam logic [31:0] ADD0  = 32'h00100133;
    localparam logic [31:0] SW    = 32'h0020A423;
    localparam logic [31:0] LW5   = 32'h0000A283;
    localparam logic [31:0] ADD6  = 32'h00028333;
    localparam logic [31:0] LUI5  = 32'h000012B7;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [31:0] ins);
        if_valid = v;
        instr    = ins;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0; if_valid = 1'b0; instr = NOP;
        d_pc = 64'h100; d_rs1 = 64'h1234; d_rs2 = 64'h0; d_wb = 64'h0; wb_rd = 5'd0; wb_we = 1'b0;
        step(); step();
        total++; if (a_instr !== NOP) begin bad++; $display("FAIL reset_instr got=%h exp=%h", a_instr, NOP); end
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", a_valid); end
        total++; if (b_ctrl !== 11'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", b_ctrl); end
        total++; if (b_hz !== 1'b0) begin bad++; $display("FAIL reset_hz got=%b exp=0", b_hz); end
        reset = 1'b0;
        step();
        $display("reset: instr=%h valid=%b", a_instr, a_valid);
    endtask

    task automatic test_addi();
        present(1'b1, ADDI);
        total++; if (a_rs2_addr !== 5'd10) begin bad++; $display("FAIL addi_rs2_comb got=%0d exp=10", a_rs2_addr); end
        step();
        total++; if (a_rd !== 5'd1) begin bad++; $display("FAIL addi_rd got=%0d exp=1", a_rd); end
        total++; if (a_rs1a !== 5'd0 || a_rs2a !== 5'd10) begin bad++; $display("FAIL addi_addr got=%0d/%0d exp=0/10", a_rs1a, a_rs2a); end
        total++; if (a_imm !== 32'hA) begin bad++; $display("FAIL addi_imm got=%h exp=a", a_imm); end
        total++; if (a_ctrl !== 11'h083) begin bad++; $display("FAIL addi_ctrl got=%h exp=083", a_ctrl); end
        total++; if (a_valid !== 1'b1 || a_pc !== 32'h100) begin bad++; $display("FAIL addi_valid_pc got=%b/%h exp=1/100", a_valid, a_pc); end
        total++; if (b_rs1d !== 64'h0) begin bad++; $display("FAIL addi_x0_data got=%h exp=0", b_rs1d); end
        $display("addi: rd=%0d imm=%h ctrl=%h", a_rd, a_imm, a_ctrl);
        present(1'b1, ADDIM);
        step();
        total++; if (b_imm !== 64'hFFFFFFFFFFFFFFFF) begin bad++; $display("FAIL addi_neg64 got=%h exp=ffffffffffffffff", b_imm); end
        total++; if (a_imm !== 32'hFFFFFFFF) begin bad++; $display("FAIL addi_neg32 got=%h exp=ffffffff", a_imm); end
        $display("addi -1: imm64=%h", b_imm);
    endtask

    task automatic test_bypass();
        d_rs1 = 64'hA; d_rs2 = 64'h5; wb_rd = 5'd2; d_wb = 64'h1E; wb_we = 1'b1;
        present(1'b1, ADD2);
        step();
        total++; if (a_rs1d !== 32'h1E) begin bad++; $display("FAIL byp_rs1 got=%h exp=1e", a_rs1d); end
        total++; if (b_rs2d !== 64'h5) begin bad++; $display("FAIL byp_rs2 got=%h exp=5", b_rs2d); end
        total++; if (a_ctrl !== 11'h081 || a_imm !== 32'h0) begin bad++; $display("FAIL byp_add_ctrl got=%h/%h exp=081/0", a_ctrl, a_imm); end
        $display("bypass: rs1=%h rs2=%h", a_rs1d, a_rs2d);
        wb_we = 1'b0;
        step();
        total++; if (b_rs1d !== 64'hA) begin bad++; $display("FAIL byp_nowrite got=%h exp=a", b_rs1d); end
        d_rs1 = 64'h77; wb_rd = 5'd0; d_wb = 64'h55; wb_we = 1'b1;
        present(1'b1, ADD0);
        step();
        total++; if (a_rs1d !== 32'h0 || b_rs1d !== 64'h0) begin bad++; $display("FAIL byp_x0 got=%h/%h exp=0", a_rs1d, b_rs1d); end
        $display("bypass x0: rs1=%h", b_rs1d);
        wb_we = 1'b0; wb_rd = 5'd0; d_wb = 64'h0;
    endtask

    task automatic test_store();
        present(1'b1, SW);
        step();
        total++; if (a_imm !== 32'h8 || a_ctrl !== 11'h00A) begin bad++; $display("FAIL store got=%h/%h exp=8/00a", a_imm, a_ctrl); end
        $display("store: imm=%h ctrl=%h", a_imm, a_ctrl);
    endtask

    task automatic test_load_use();
        present(1'b1, LW5);
        step();
        total++; if (a_ctrl !== 11'h017) begin bad++; $display("FAIL lu_load_ctrl got=%h exp=017", a_ctrl); end
        present(1'b1, ADD6);
        total++; if (a_hz !== 1'b1 || b_hz !== 1'b1) begin bad++; $display("FAIL lu_detect got=%b/%b exp=1/1", a_hz, b_hz); end
        step();
        total++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble1 got=%b/%b exp=0/0", a_valid, b_valid); end
        total++; if (a_hz !== 1'b0 || b_hz !== 1'b1) begin bad++; $display("FAIL lu_hz_after1 got=%b/%b exp=0/1", a_hz, b_hz); end
        step();
        total++; if (a_valid !== 1'b1 || a_instr !== ADD6) begin bad++; $display("FAIL lu_a_issue got=%b/%h exp=1/%h", a_valid, a_instr, ADD6); end
        total++; if (b_valid !== 1'b0 || b_hz !== 1'b0) begin bad++; $display("FAIL lu_b_bubble2 got=%b/%b exp=0/0", b_valid, b_hz); end
        step();
        total++; if (b_valid !== 1'b1 || b_rs1a !== 5'd5) begin bad++; $display("FAIL lu_b_issue got=%b/%0d exp=1/5", b_valid, b_rs1a); end
        $display("load-use: a_valid=%b b_valid=%b", a_valid, b_valid);
    endtask

    task automatic test_bubble_stall();
        present(1'b1, LW5);
        step();
        present(1'b1, ADD6);
        step();
        stall = 1'b1;
        step(); step();
        total++; if (b_hz !== 1'b1 || b_valid !== 1'b0) begin bad++; $display("FAIL bst_hold got=%b/%b exp=1/0", b_hz, b_valid); end
        stall = 1'b0;
        step();
        total++; if (b_hz !== 1'b0 || b_valid !== 1'b0) begin bad++; $display("FAIL bst_release got=%b/%b exp=0/0", b_hz, b_valid); end
        step();
        total++; if (b_valid !== 1'b1) begin bad++; $display("FAIL bst_issue got=%b exp=1", b_valid); end
        $display("bubble+stall: b_valid=%b", b_valid);
    endtask

    task automatic test_bubble_flush();
        present(1'b1, LW5);
        step();
        present(1'b1, ADD6);
        step();
        stall = 1'b1; flush = 1'b1;
        step();
        total++; if (b_hz !== 1'b0 || b_valid !== 1'b0) begin bad++; $display("FAIL bfl_run got=%b/%b exp=0/0", b_hz, b_valid); end
        total++; if (a_valid !== 1'b0 || a_ctrl !== 11'h0 || a_instr !== NOP) begin bad++; $display("FAIL bfl_a_bubble got=%b/%h/%h exp=0/0/%h", a_valid, a_ctrl, a_instr, NOP); end
        stall = 1'b0; flush = 1'b0;
        step();
        total++; if (b_valid !== 1'b1) begin bad++; $display("FAIL bfl_issue got=%b exp=1", b_valid); end
        $display("bubble+flush: b_hz=%b b_valid=%b", b_hz, b_valid);
    endtask

    task automatic test_lui_stall_flush();
        present(1'b1, LW5);
        step();
        present(1'b1, LUI5);
        total++; if (a_hz !== 1'b0 || b_hz !== 1'b0) begin bad++; $display("FAIL lui_nohz got=%b/%b exp=0/0", a_hz, b_hz); end
        step();
        total++; if (a_imm !== 32'h1000 || a_rd !== 5'd5 || a_valid !== 1'b1) begin bad++; $display("FAIL lui_load got=%h/%0d/%b exp=1000/5/1", a_imm, a_rd, a_valid); end
        stall = 1'b1;
        present(1'b1, ADDI);
        step();
        total++; if (a_instr !== LUI5 || b_imm !== 64'h1000 || b_valid !== 1'b1) begin bad++; $display("FAIL stall_hold got=%h/%h/%b exp=%h/1000/1", a_instr, b_imm, b_valid, LUI5); end
        flush = 1'b1;
        step();
        total++; if (a_valid !== 1'b0 || a_ctrl !== 11'h0 || a_instr !== NOP) begin bad++; $display("FAIL flush_stall got=%b/%h/%h exp=0/0/%h", a_valid, a_ctrl, a_instr, NOP); end
        stall = 1'b0; flush = 1'b0;
        $display("lui/stall/flush: instr=%h", a_instr);
    endtask

    task automatic test_invalid_and_reset_mid();
        present(1'b0, ADDI);
        step();
        total++; if (a_valid !== 1'b0 || a_instr !== NOP) begin bad++; $display("FAIL invalid_bubble got=%b/%h exp=0/%h", a_valid, a_instr, NOP); end
        present(1'b1, LW5);
        step();
        present(1'b1, ADD6);
        step();
        reset = 1'b1;
        step();
        total++; if (b_hz !== 1'b0 || b_instr !== NOP || b_valid !== 1'b0) begin bad++; $display("FAIL reset_mid got=%b/%h/%b exp=0/%h/0", b_hz, b_instr, b_valid, NOP); end
        reset = 1'b0;
        $display("invalid/reset-mid: hz=%b", b_hz);
    endtask

    initial begin
        test_reset();
        test_addi();
        test_bypass();
        test_store();
        test_load_use();
        test_bubble_stall();
        test_bubble_flush();
        test_lui_stall_flush();
        test_invalid_and_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
